gray_decode_arbiter: RTL and testbench
======================================

GRAY_DECODE_ARBITER -- requirements
Module: gray_decode_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, Gray/binary word width.
REQ-002 SHALL have parameter N_REQ, fixed at 2, number of requesters.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester request valid.
REQ-006 SHALL have port req_gray  input  N_REQ x WIDTH  per-requester Gray code word.
REQ-007 SHALL have port req_ready  output  N_REQ  per-requester accept, one-hot or zero.
REQ-008 SHALL have port rsp_valid  output  1  converted result valid.
REQ-009 SHALL have port rsp_bin  output  WIDTH  binary result.
REQ-010 SHALL have port rsp_id  output  1  index of the requester that owns rsp_bin.
REQ-011 SHALL have port rsp_ready  input  1  consumer accept.
REQ-012 SHALL have port done_count  output  16  count of completed responses.

Function
REQ-013 SHALL implement FSM states IDLE, CONV and RESP.
REQ-014 IDLE SHALL assert req_ready only for the granted requester, when at least one req_valid is high.
REQ-015 A request is accepted when req_valid and req_ready are both high at a rising edge; the edge captures req_gray and the requester id into the input register and moves the FSM to CONV.
REQ-016 CONV SHALL compute binary as b[WIDTH-1]=g[WIDTH-1] and b[i]=b[i+1] XOR g[i].
REQ-017 CONV SHALL register the result into rsp_bin and rsp_id, then move the FSM to RESP unconditionally.
REQ-018 RESP SHALL hold rsp_valid high with rsp_bin and rsp_id stable until rsp_ready is high at a rising edge, then return to IDLE.
REQ-019 rsp_valid SHALL rise exactly 2 cycles after the accept edge; peak throughput is one result per 3 cycles.
REQ-020 req_ready SHALL be all-zero in CONV and RESP; a requester that drops req_valid before being granted is legal and loses nothing.
REQ-021 With no req_valid high, the FSM SHALL remain in IDLE.
REQ-022 done_count SHALL increment on each rsp_valid and rsp_ready handshake and saturate at 16'hFFFF.
REQ-023 Every Gray input SHALL map to a defined result; no X is allowed on rsp_bin.

Reset
REQ-024 While rst_n is low, the block SHALL be in IDLE with req_ready=0, rsp_valid=0, rsp_bin=0, rsp_id=0, done_count=0, and the grant pointer favouring requester 0.
REQ-025 Reset asserted mid-operation SHALL discard the in-flight request without producing a response; after release the block starts in IDLE.

Configuration
REQ-026 With macro GRAY_ARB_ROUND_ROBIN_EN defined, when both requesters are valid in IDLE the grant SHALL go to the requester not granted last (pointer updates on accept).
REQ-027 Without GRAY_ARB_ROUND_ROBIN_EN, the grant SHALL use fixed priority: requester 0 always wins ties, and no pointer register exists.

Structure
REQ-028 Shared package gray_pkg SHALL hold the WIDTH default constant, the N_REQ constant and the FSM state enum typedef.
REQ-029 The combinational Gray-to-binary function SHALL be a sub-module named gray_to_bin_core, instantiated once and driven from the input register.

Verification
REQ-030 Reset, then req0 sends 4'b1000 with rsp_ready=1 -> rsp_valid high 2 cycles after accept, rsp_bin=4'b1111, rsp_id=0, done_count=1.
REQ-031 Sweep all 16 Gray codes on req1 -> rsp_bin equals the binary index for each (e.g. 4'b0011 -> 4'b0010), rsp_id=1.
REQ-032 Both requesters held valid for 4 requests -> with the macro, grants are 0,1,0,1; without it, grants are 0,0,0,0.
REQ-033 rsp_ready held low for 5 cycles in RESP -> rsp_bin is stable, req_ready=0 throughout, done_count is unchanged until the handshake.
REQ-034 rst_n pulsed low during CONV -> all outputs are 0 asynchronously, and no response appears after release.
REQ-035 done_count preloaded near 16'hFFFF via 3 handshakes -> the count holds at 16'hFFFF.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared constants and FSM state type for the Gray-decode arbiter.
package gray_pkg;

  localparam int unsigned GRAY_WIDTH = 4;
  localparam int unsigned GRAY_N_REQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/gray_to_bin_core.sv
// Combinational Gray-to-binary conversion: each binary bit is the running XOR from the MSB down.
module gray_to_bin_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  always_comb begin
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = gray_i[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gray_i[i];
    end
    bin_o = b;
  end

endmodule

// File: rtl/gray_decode_arbiter.sv
// Two-requester arbiter feeding a registered Gray-to-binary converter with a valid/ready response.
// Define GRAY_ARB_ROUND_ROBIN_EN for round-robin ties; default build uses fixed priority (requester 0).
module gray_decode_arbiter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_WIDTH,
  parameter int unsigned N_REQ = GRAY_N_REQ
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_gray,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rsp_valid,
  output logic [WIDTH-1:0]         rsp_bin,
  output logic                     rsp_id,
  input  logic                     rsp_ready,
  output logic [15:0]              done_count
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] rsp_bin_q, rsp_bin_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [15:0]      done_count_q, done_count_d;

  logic             grant_id;
  logic             any_valid;
  logic             accept;
  logic [WIDTH-1:0] sel_gray;
  logic [WIDTH-1:0] conv_bin;

  assign any_valid = |req_valid;

`ifdef GRAY_ARB_ROUND_ROBIN_EN
  // ptr_q names the requester favoured on the next tie
  logic ptr_q, ptr_d;

  always_comb begin
    grant_id = (req_valid[0] && req_valid[1]) ? ptr_q : !req_valid[0];
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = !grant_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    grant_id = !req_valid[0];
  end
`endif

  // Ready is qualified by rst_n so it reads zero for the whole reset window
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && any_valid && rst_n) req_ready[grant_id] = 1'b1;
  end

  assign accept   = |(req_valid & req_ready);
  assign sel_gray = grant_id ? req_gray[WIDTH +: WIDTH] : req_gray[0 +: WIDTH];

  gray_to_bin_core #(.WIDTH(WIDTH)) u_core (
    .gray_i (gray_q),
    .bin_o  (conv_bin)
  );

  always_comb begin
    state_d      = state_q;
    gray_d       = gray_q;
    id_d         = id_q;
    rsp_bin_d    = rsp_bin_q;
    rsp_id_d     = rsp_id_q;
    rsp_valid_d  = rsp_valid_q;
    done_count_d = done_count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          gray_d  = sel_gray;
          id_d    = grant_id;
          state_d = CONV;
        end
      end
      CONV: begin
        rsp_bin_d   = conv_bin;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
          if (done_count_q != 16'hFFFF) done_count_d = done_count_q + 16'd1;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gray_q       <= '0;
      id_q         <= 1'b0;
      rsp_bin_q    <= '0;
      rsp_id_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      gray_q       <= gray_d;
      id_q         <= id_d;
      rsp_bin_q    <= rsp_bin_d;
      rsp_id_q     <= rsp_id_d;
      rsp_valid_q  <= rsp_valid_d;
      done_count_q <= done_count_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_bin    = rsp_bin_q;
  assign rsp_id     = rsp_id_q;
  assign done_count = done_count_q;

endmodule

// File: tb/tb_gray_decode_arbiter.sv
// Directed scoreboard bench for gray_decode_arbiter (fixed-priority or GRAY_ARB_ROUND_ROBIN_EN build).
module tb_gray_decode_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [7:0]  req_gray;
  logic [1:0]  req_ready;
  logic        rsp_valid;
  logic [3:0]  rsp_bin;
  logic        rsp_id;
  logic        rsp_ready;
  logic [15:0] done_count;

  int nvec = 0;
  int nerr = 0;
  logic [15:0] mdl_cnt;
  logic [4:0]  sb[$];

  gray_decode_arbiter #(.WIDTH(4), .N_REQ(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_gray   (req_gray),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_bin    (rsp_bin),
    .rsp_id     (rsp_id),
    .rsp_ready  (rsp_ready),
    .done_count (done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Binary bit k is the parity of all Gray bits at or above k
  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    for (int k = 0; k < 4; k++) b[k] = ^(g >> k);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bump_model();
    if (mdl_cnt != 16'hFFFF) mdl_cnt = mdl_cnt + 16'd1;
  endtask

  // One request through accept, conversion, optional stall and response handshake
  task automatic run_txn(input logic [1:0] vld, input logic [3:0] g0, input logic [3:0] g1,
                         input logic exp_id, input int stall, input string tag);
    logic [4:0] exp;
    int lat;
    @(negedge clk);
    req_valid = vld;
    req_gray  = {g1, g0};
    rsp_ready = 1'b0;
    #1;
    chk({tag, "_grant"}, 32'(req_ready), exp_id ? 32'd2 : 32'd1);
    sb.push_back({exp_id, g2b(exp_id ? g1 : g0)});
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      chk({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
    end while (!rsp_valid && lat < 10);
    chk({tag, "_latency"}, 32'(lat), 32'd2);
    repeat (stall) begin
      @(negedge clk);
      chk({tag, "_stall_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_stall_bin"}, 32'(rsp_bin), 32'(sb[0][3:0]));
      chk({tag, "_stall_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_stall_count"}, 32'(done_count), 32'(mdl_cnt));
    end
    rsp_ready = 1'b1;
    exp = sb.pop_front();
    chk({tag, "_bin"}, 32'(rsp_bin), 32'(exp[3:0]));
    chk({tag, "_id"}, 32'(rsp_id), 32'(exp[4]));
    @(posedge clk);
    bump_model();
    #1;
    chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_count"}, 32'(done_count), 32'(mdl_cnt));
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] g;
    logic       rr_exp [4];
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_gray  = 8'hA5;
    rsp_ready = 1'b0;
    mdl_cnt   = 16'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_bin", 32'(rsp_bin), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_count", 32'(done_count), 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with no requests stays idle
    repeat (3) begin
      @(negedge clk);
      chk("idle_valid", 32'(rsp_valid), 32'd0);
    end

    run_txn(2'b01, 4'b1000, 4'b0000, 1'b0, 0, "req0_1000");
    req_valid = 2'b00;

    // Full Gray sweep on requester 1
    for (int i = 0; i < 16; i++) begin
      g = 4'(i) ^ (4'(i) >> 1);
      run_txn(2'b10, 4'b0000, g, 1'b1, 0, "sweep");
      nvec++;
      assert (g2b(g) === 4'(i)) else begin
        nerr++;
        $error("FAIL sweep_model: observed %0h expected %0h", g2b(g), 4'(i));
      end
    end
    req_valid = 2'b00;

`ifdef GRAY_ARB_ROUND_ROBIN_EN
    rr_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    rr_exp = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 4; i++) begin
      run_txn(2'b11, 4'(3 + i), 4'(9 + i), rr_exp[i], 0, "both");
    end
    req_valid = 2'b00;

    run_txn(2'b01, 4'b0110, 4'b0000, 1'b0, 5, "stall");
    run_txn(2'b10, 4'b0000, 4'b1101, 1'b1, 0, "post_stall");
    req_valid = 2'b00;

    // Reset during CONV drops the in-flight request
    @(negedge clk);
    req_valid = 2'b01;
    req_gray  = 8'h0B;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(req_ready), 32'd0);
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_bin", 32'(rsp_bin), 32'd0);
    chk("midrst_id", 32'(rsp_id), 32'd0);
    chk("midrst_count", 32'(done_count), 32'd0);
    mdl_cnt   = 16'd0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("midrst_count_after", 32'(done_count), 32'd0);
    rsp_ready = 1'b0;

    // Saturation: preload the counter close to the top
    @(negedge clk);
    force dut.done_count_q = 16'hFFFD;
    #1;
    release dut.done_count_q;
    mdl_cnt = 16'hFFFD;
    @(negedge clk);
    chk("sat_preload", 32'(done_count), 32'hFFFD);
    for (int i = 0; i < 4; i++) begin
      run_txn(2'b10, 4'b0000, 4'(i), 1'b1, 0, "sat");
    end
    req_valid = 2'b00;
    chk("sat_hold", 32'(done_count), 32'hFFFF);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
